uart_tx_packet: RTL
===================

Name: uart_tx_packet

Overview:
Parametrised UART transmitter and successor to the single-byte serial TX. It latches a wide payload on a trigger and sends it as NUM_WORDS back-to-back UART frames, word 0 first. Data width, parity mode and stop-bit count are configurable, and it reports busy/done to the controlling FSM. It sits between the game-state logic, which produces the 162-bit board payload, and the board's UART TX pin.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate; DIVISOR = CLK_HZ/BAUD_RATE (integer division, truncated), must be >= 2
DATA_BITS, 8, data bits per frame (5..9)
NUM_WORDS, 21, frames per packet (21*8 = 168 bits covers the 162-bit payload; upper bits are zero-padded by the caller)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
trigger_in  input  1  start request, single-cycle or level; sampled only when idle
val_in  input  NUM_WORDS*DATA_BITS  payload; word k = val_in[k*DATA_BITS +: DATA_BITS]
busy_out  output  1  high from the cycle after acceptance until the packet completes
done_out  output  1  one-cycle pulse when the final stop bit period ends
data_out  output  1  serial line, idle high, registered

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - data_out = 1, busy_out = 0, done_out = 0.
  - State goes to IDLE; word index, bit index and baud counter are cleared.
  - An in-progress packet is abandoned, not resumed.
- Acceptance:
  - In IDLE, trigger_in = 1 latches all of val_in into an internal shift register and enters START.
  - From the next cycle, data_out = 0 and busy_out = 1.
  - trigger_in is ignored while busy_out = 1.
  - Changes to val_in after acceptance have no effect.
- States: IDLE -> START -> DATA -> (PARITY if PARITY != 0) -> STOP -> START (next word) or IDLE (last word).
- Bit timing:
  - Every line bit is held exactly DIVISOR cycles.
  - The baud counter restarts at acceptance, so there is no partial first bit.
  - State advances on the cycle the counter reaches 0.
- Bit order and levels:
  - DATA sends the current word LSB first, DATA_BITS bits.
  - PARITY bit makes the count of ones in data+parity odd (PARITY = 1) or even (PARITY = 2).
  - STOP drives 1 for STOP_BITS bit periods.
- Inter-word: the next word's start bit follows the last stop bit with no idle gap.
- Completion:
  - After the last stop bit of word NUM_WORDS-1, return to IDLE.
  - In that same cycle busy_out = 0 and done_out = 1 for exactly one cycle; data_out stays 1.
- Back-to-back: trigger_in high in the done_out cycle is accepted (state is IDLE). The line then shows exactly STOP_BITS high periods before the new start bit, with no extra gap cycles beyond one.
- Packet length: NUM_WORDS*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS)*DIVISOR cycles, from the first low cycle on data_out to done_out.
- Width rules:
  - Baud counter is $clog2(DIVISOR) bits.
  - Word index is $clog2(NUM_WORDS) bits (min 1).
  - Bit index is $clog2(DATA_BITS+1) bits.
  - No counter wraps during legal operation.

Decomposition:
- Package uart_pkg holds:
  - parity_e (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e (IDLE, START, DATA, PARITY, STOP)
  - function divisor(clk_hz, baud)
- Sub-module baud_tick_gen:
  - Parameter DIVISOR; inputs clk_in, rst_in, restart_in; output tick_out.
  - tick_out pulses every DIVISOR cycles after restart_in.
  - Reused by the future RX block.

Test Plan:
1. CLK_HZ=1_000_000, BAUD_RATE=100_000 (DIVISOR=10), PARITY=0, STOP_BITS=1, NUM_WORDS=1; trigger with val_in=8'hA5 -> line low 10 cycles, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; done_out pulses once, 100 cycles after the first low cycle.
2. NUM_WORDS=3, val_in=24'h0201FF -> frames FF, 01, 02 in order, no idle gap between stop and start; busy_out high for exactly 300 cycles.
3. PARITY=1 with 8'h03 -> parity bit 1; PARITY=2 with 8'h03 -> parity bit 0; frame is 110 cycles; STOP_BITS=2 -> frame is 120 cycles.
4. Pulse trigger_in again mid-packet with different val_in -> ignored, transmitted data unchanged, single done_out pulse.
5. Assert rst_in asynchronously (between clock edges) during the DATA bit 3 period -> data_out = 1 and busy_out = 0 immediately without a clock edge; a later trigger sends a complete, correct frame.
6. Hold trigger_in high continuously with NUM_WORDS=1 -> packets repeat; each begins exactly one cycle after done_out; every frame decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
//   parity_e   : parity mode selector (none / odd / even)
//   tx_state_e : transmitter frame states
//   divisor()  : clock cycles per line bit, CLK_HZ / BAUD_RATE truncated
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int unsigned divisor(input int unsigned clk_hz,
                                          input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator, shared by the UART TX and RX paths.
//   clk_in     : system clock
//   rst_in     : asynchronous active-high reset, clears the counter
//   restart_in : reload the counter so the next tick lands DIVISOR cycles later
//   tick_out   : one-cycle pulse every DIVISOR cycles
module baud_tick_gen #(
  parameter int unsigned DIVISOR = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart_in,
  output logic tick_out
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else if (restart_in || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A restart cycle never produces a tick, so the first period is always full.
  assign tick_out = (cnt_q == '0) && !restart_in;

endmodule

// File: rtl/uart_tx_packet.sv
// Multi-word UART transmitter: latches a NUM_WORDS*DATA_BITS payload on a
// trigger and sends it as back-to-back frames, word 0 first, LSB first.
//   clk_in     : system clock
//   rst_in     : asynchronous active-high reset; abandons any packet
//   trigger_in : start request, sampled only while idle
//   val_in     : payload, word k = val_in[k*DATA_BITS +: DATA_BITS]
//   busy_out   : high while a packet is in flight
//   done_out   : one-cycle pulse as the final stop bit ends
//   data_out   : registered serial line, idle high
module uart_tx_packet
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned NUM_WORDS = 21,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           trigger_in,
  input  logic [NUM_WORDS*DATA_BITS-1:0] val_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           data_out
);

  localparam int unsigned DIVISOR = divisor(CLK_HZ, BAUD_RATE);
  localparam int unsigned WORD_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
  localparam int unsigned PKT_W   = NUM_WORDS * DATA_BITS;
  localparam parity_e     PAR_MODE = parity_e'(2'(PARITY));

  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

  tx_state_e            state_q, state_d;
  logic [PKT_W-1:0]     pkt_q, pkt_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 par_q, par_d;
  logic [WORD_W-1:0]    word_idx_q, word_idx_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
  logic                 restart;
  logic                 tick;

  baud_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .restart_in(restart),
    .tick_out  (tick)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      word_q     <= '0;
      par_q      <= 1'b0;
      word_idx_q <= '0;
      bit_idx_q  <= '0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      word_q     <= word_d;
      par_q      <= par_d;
      word_idx_q <= word_idx_d;
      bit_idx_q  <= bit_idx_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

  // The line is registered, so each branch drives the level of the bit that
  // the state being entered will present from the next cycle on.
  // Words are consumed by shifting pkt_q down one word per frame; word_q
  // shifts one bit per data period, so the current bit is always word_q[0].
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    word_d     = word_q;
    par_d      = par_q;
    word_idx_d = word_idx_q;
    bit_idx_d  = bit_idx_q;
    line_d     = line_q;
    done_d     = 1'b0;
    restart    = 1'b0;

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (trigger_in) begin
          pkt_d      = val_in;
          word_idx_d = '0;
          bit_idx_d  = '0;
          restart    = 1'b1;
          line_d     = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (tick) begin
          word_d    = pkt_q[DATA_BITS-1:0];
          pkt_d     = pkt_q >> DATA_BITS;
          par_d     = 1'b0;
          bit_idx_d = '0;
          line_d    = pkt_q[0];
          state_d   = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          par_d  = par_q ^ word_q[0];
          word_d = word_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            if (PAR_MODE != PAR_NONE) begin
              state_d = uart_pkg::PARITY;
              line_d  = (PAR_MODE == PAR_ODD) ? ~par_d : par_d;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            line_d    = word_q[1];
          end
        end
      end

      uart_pkg::PARITY: begin
        if (tick) begin
          bit_idx_d = '0;
          line_d    = 1'b1;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            if (word_idx_q == LAST_WORD) begin
              line_d  = 1'b1;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              word_idx_d = word_idx_q + 1'b1;
              line_d     = 1'b0;
              state_d    = START;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      default: begin
        line_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign busy_out = (state_q != IDLE);
  assign done_out = done_q;
  assign data_out = line_q;

endmodule
